// File: rtl/ref_sync_pkg.sv
// ============================================================================
// Module   : ref_sync_pkg
// Purpose  : Shared types and default widths for the multi-channel reference
//            synchroniser (ref_sync_meter / ref_sync_chan).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ref_sync_pkg;

  // Per-channel alignment state: IDLE counts harmonic edges, ARMED waits for
  // the first qualifying edge after a second pulse.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chan_state_t;

  localparam int unsigned DEF_NCH     = 4;
  localparam int unsigned DEF_ADC_CH  = 16;
  localparam int unsigned DEF_GARM_W  = 24;
  localparam int unsigned DEF_LAG_W   = 16;
  localparam int unsigned DEF_MEAS_W  = 6;
  localparam int unsigned DEF_DGL_LEN = 4;

  // Value reported in lag_fix when the sync had to be forced.
  localparam logic [DEF_LAG_W-1:0] LAG_SAT = '1;

endpackage

`default_nettype wire

// File: rtl/ref_sync_chan.sv
// ============================================================================
// Module   : ref_sync_chan
// Purpose  : One reference channel: sample select, optional deglitch, edge
//            detect, IDLE/ARMED alignment FSM, lag/period/seconds counters.
// Config   : REF_SYNC_DEGLITCH_EN - require DGL_LEN equal raw samples before
//            accepting a new sign (adds DGL_LEN clocks of latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_sync_chan
  import ref_sync_pkg::*;
#(
  parameter int unsigned ADC_CH  = DEF_ADC_CH,
  parameter int unsigned SEL_W   = $clog2(ADC_CH),
  parameter int unsigned GARM_W  = DEF_GARM_W,
  parameter int unsigned LAG_W   = DEF_LAG_W,
  parameter int unsigned MEAS_W  = DEF_MEAS_W,
  parameter int unsigned DGL_LEN = DEF_DGL_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADC_CH-1:0] adc_data,
  input  logic                sec_pulse,
  input  logic                en,
  input  logic                edge_sel,
  input  logic [SEL_W-1:0]    sel,
  input  logic [LAG_W-1:0]    timeout_lim,
  output logic                sync_out,
  output logic                fix_stb,
  output logic [LAG_W-1:0]    lag_fix,
  output logic [GARM_W-1:0]   garm_fix,
  output logic [MEAS_W-1:0]   meas_fix,
  output logic                timeout
);

  if (DGL_LEN < 1) begin : g_dgl_check
    $error("ref_sync_chan: DGL_LEN must be at least 1");
  end

  logic        raw_sign;
  logic        sign_in;
  logic        sign_s1;
  logic        sign_s2;
  logic        edge_det;

  chan_state_t           state;
  logic [LAG_W-1:0]      lag_cnt;
  logic [GARM_W-1:0]     garm_cnt;
  logic [GARM_W-1:0]     garm_next;
  logic [MEAS_W-1:0]     meas_cnt;

  // Sign bit of sample k lives at bit 2k+1.
  assign raw_sign = adc_data[{sel, 1'b1}];

`ifdef REF_SYNC_DEGLITCH_EN
  localparam int unsigned DGL_CW = (DGL_LEN > 1) ? $clog2(DGL_LEN) : 1;

  logic [DGL_CW-1:0] dgl_cnt;
  logic              dgl_sign;

  // Accept a new sign only after DGL_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dgl_cnt  <= '0;
      dgl_sign <= 1'b0;
    end else if (raw_sign == dgl_sign) begin
      dgl_cnt  <= '0;
    end else if (dgl_cnt == DGL_CW'(DGL_LEN - 1)) begin
      dgl_sign <= raw_sign;
      dgl_cnt  <= '0;
    end else begin
      dgl_cnt  <= dgl_cnt + 1'b1;
    end
  end

  assign sign_in = dgl_sign;
`else
  assign sign_in = raw_sign;
`endif

  // Two-stage sign history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_s1 <= 1'b0;
      sign_s2 <= 1'b0;
    end else begin
      sign_s1 <= sign_in;
      sign_s2 <= sign_s1;
    end
  end

  assign edge_det  = edge_sel ? (sign_s1 & ~sign_s2) : (~sign_s1 & sign_s2);
  assign garm_next = (edge_det && (garm_cnt != '1)) ? garm_cnt + 1'b1 : garm_cnt;

  // Alignment FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lag_cnt  <= '0;
      garm_cnt <= '0;
      meas_cnt <= '0;
      sync_out <= 1'b0;
      fix_stb  <= 1'b0;
      lag_fix  <= '0;
      garm_fix <= '0;
      meas_fix <= '0;
      timeout  <= 1'b0;
    end else begin
      sync_out <= 1'b0;
      fix_stb  <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else if (sec_pulse) begin
        // A coincident edge is counted but can never be the sync edge.
        garm_fix <= garm_next;
        garm_cnt <= garm_next;
        meas_fix <= meas_cnt;
        meas_cnt <= meas_cnt + 1'b1;
        lag_cnt  <= '0;
        state    <= ARMED;
        if (state == ARMED) begin
          timeout <= 1'b1;
        end
      end else if (state == ARMED) begin
        if (edge_det) begin
          sync_out <= 1'b1;
          fix_stb  <= 1'b1;
          lag_fix  <= lag_cnt;
          garm_cnt <= '0;
          timeout  <= 1'b0;
          state    <= IDLE;
        end else if ((timeout_lim != '0) && (lag_cnt == (timeout_lim - LAG_W'(1)))) begin
          sync_out <= 1'b1;
          fix_stb  <= 1'b1;
          lag_fix  <= '1;
          timeout  <= 1'b1;
          state    <= IDLE;
        end else if (lag_cnt != '1) begin
          lag_cnt  <= lag_cnt + 1'b1;
        end
      end else begin
        garm_cnt <= garm_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ref_sync_meter.sv
// ============================================================================
// Module   : ref_sync_meter
// Purpose  : NCH-channel reference-input interpreter: aligns a sync pulse to
//            a selected ADC sign edge after each second pulse and measures
//            lag, harmonic periods per second and a seconds count.
// Config   : REF_SYNC_DEGLITCH_EN - enables the per-channel sign deglitcher.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ref_sync_meter
  import ref_sync_pkg::*;
#(
  parameter int unsigned NCH     = DEF_NCH,
  parameter int unsigned ADC_CH  = DEF_ADC_CH,
  parameter int unsigned SEL_W   = $clog2(ADC_CH),
  parameter int unsigned GARM_W  = DEF_GARM_W,
  parameter int unsigned LAG_W   = DEF_LAG_W,
  parameter int unsigned MEAS_W  = DEF_MEAS_W,
  parameter int unsigned DGL_LEN = DEF_DGL_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2*ADC_CH-1:0]   adc_data,
  input  logic                  sec_pulse,
  input  logic [NCH-1:0]        cfg_en,
  input  logic [NCH-1:0]        cfg_edge,
  input  logic [NCH*SEL_W-1:0]  cfg_sel,
  input  logic [LAG_W-1:0]      cfg_timeout,
  output logic [NCH-1:0]        sync_out,
  output logic [NCH-1:0]        fix_stb,
  output logic [NCH*LAG_W-1:0]  lag_fix,
  output logic [NCH*GARM_W-1:0] garm_fix,
  output logic [NCH*MEAS_W-1:0] meas_fix,
  output logic [NCH-1:0]        timeout
);

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    ref_sync_chan #(
      .ADC_CH  (ADC_CH),
      .SEL_W   (SEL_W),
      .GARM_W  (GARM_W),
      .LAG_W   (LAG_W),
      .MEAS_W  (MEAS_W),
      .DGL_LEN (DGL_LEN)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .adc_data    (adc_data),
      .sec_pulse   (sec_pulse),
      .en          (cfg_en[ch]),
      .edge_sel    (cfg_edge[ch]),
      .sel         (cfg_sel[ch*SEL_W +: SEL_W]),
      .timeout_lim (cfg_timeout),
      .sync_out    (sync_out[ch]),
      .fix_stb     (fix_stb[ch]),
      .lag_fix     (lag_fix[ch*LAG_W +: LAG_W]),
      .garm_fix    (garm_fix[ch*GARM_W +: GARM_W]),
      .meas_fix    (meas_fix[ch*MEAS_W +: MEAS_W]),
      .timeout     (timeout[ch])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_ref_sync_meter.sv
// ============================================================================
// Module   : tb_ref_sync_meter
// Purpose  : Directed self-checking bench for ref_sync_meter.
// Config   : REF_SYNC_DEGLITCH_EN - shifts expected latency by DGL_LEN and
//            adds a glitch-rejection scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ref_sync_meter;

`ifdef REF_SYNC_DEGLITCH_EN
  localparam int X = 4;
`else
  localparam int X = 0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] adc_data;
  logic        sec_pulse;
  logic [3:0]  cfg_en;
  logic [3:0]  cfg_edge;
  logic [15:0] cfg_sel;
  logic [15:0] cfg_timeout;
  logic [3:0]  sync_out;
  logic [3:0]  fix_stb;
  logic [63:0] lag_fix;
  logic [95:0] garm_fix;
  logic [23:0] meas_fix;
  logic [3:0]  timeout;

  int checks = 0;
  int errors = 0;

  ref_sync_meter dut (
    .clk         (clk),
    .rst         (rst),
    .adc_data    (adc_data),
    .sec_pulse   (sec_pulse),
    .cfg_en      (cfg_en),
    .cfg_edge    (cfg_edge),
    .cfg_sel     (cfg_sel),
    .cfg_timeout (cfg_timeout),
    .sync_out    (sync_out),
    .fix_stb     (fix_stb),
    .lag_fix     (lag_fix),
    .garm_fix    (garm_fix),
    .meas_fix    (meas_fix),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse();
    sec_pulse = 1'b1;
    step();
    sec_pulse = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step_n(3);
    rst = 1'b0;
    step();
    checks++; if (sync_out !== 4'h0) begin errors++; $display("FAIL reset_sync got %h want 0", sync_out); end
    checks++; if (fix_stb !== 4'h0) begin errors++; $display("FAIL reset_stb got %h want 0", fix_stb); end
    checks++; if (lag_fix !== 64'h0) begin errors++; $display("FAIL reset_lag got %h want 0", lag_fix); end
    checks++; if (garm_fix !== 96'h0) begin errors++; $display("FAIL reset_garm got %h want 0", garm_fix); end
    checks++; if (meas_fix !== 24'h0) begin errors++; $display("FAIL reset_meas got %h want 0", meas_fix); end
    checks++; if (timeout !== 4'h0) begin errors++; $display("FAIL reset_timeout got %h want 0", timeout); end
  endtask

  // Ch0 rising: sign rises 6 cycles after the pulse cycle -> lag 6.
  task automatic test_lag();
    cfg_en = 4'b0001;
    step_n(2);
    pulse();
    checks++; if (garm_fix[23:0] !== 24'd0) begin errors++; $display("FAIL lag_garm0 got %0d want 0", garm_fix[23:0]); end
    checks++; if (meas_fix[5:0] !== 6'd0) begin errors++; $display("FAIL lag_meas0 got %0d want 0", meas_fix[5:0]); end
    step_n(5);
    adc_data[1] = 1'b1;
    step_n(1 + X);
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL lag_early got %b want 0000", sync_out); end
    step();
    checks++; if (sync_out !== 4'b0001) begin errors++; $display("FAIL lag_sync got %b want 0001", sync_out); end
    checks++; if (fix_stb !== 4'b0001) begin errors++; $display("FAIL lag_stb got %b want 0001", fix_stb); end
    checks++; if (lag_fix[15:0] !== 16'(6 + X)) begin errors++; $display("FAIL lag_val got %0d want %0d", lag_fix[15:0], 6 + X); end
    step();
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL lag_oneclk got %b want 0000", sync_out); end
    checks++; if (timeout !== 4'b0000) begin errors++; $display("FAIL lag_timeout got %b want 0000", timeout); end
  endtask

  // Ch0: three IDLE edges plus one coincident with the pulse -> garm 4;
  // sync then lands on the next rising edge.
  task automatic test_coincident();
    for (int i = 0; i < 3; i++) begin
      adc_data[1] = 1'b0; step_n(6);
      adc_data[1] = 1'b1; step_n(6);
    end
    adc_data[1] = 1'b0; step_n(6);
    adc_data[1] = 1'b1;
    step_n(1 + X);
    pulse();
    checks++; if (garm_fix[23:0] !== 24'd4) begin errors++; $display("FAIL coin_garm got %0d want 4", garm_fix[23:0]); end
    checks++; if (meas_fix[5:0] !== 6'd1) begin errors++; $display("FAIL coin_meas got %0d want 1", meas_fix[5:0]); end
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL coin_nosync got %b want 0000", sync_out); end
    step();
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL coin_nosync2 got %b want 0000", sync_out); end
    adc_data[1] = 1'b0; step_n(6);
    adc_data[1] = 1'b1;
    step_n(2 + X);
    checks++; if (sync_out !== 4'b0001) begin errors++; $display("FAIL coin_sync got %b want 0001", sync_out); end
    checks++; if (lag_fix[15:0] !== 16'(8 + X)) begin errors++; $display("FAIL coin_lag got %0d want %0d", lag_fix[15:0], 8 + X); end
  endtask

  // Disabled ch0 ignores edges and pulses; fix values hold.
  task automatic test_disable();
    int seen;
    seen = 0;
    cfg_en = 4'b0000;
    adc_data[1] = 1'b0; step_n(6);
    adc_data[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin step(); if (sync_out[0]) seen++; end
    pulse();
    checks++; if (seen !== 0) begin errors++; $display("FAIL dis_sync got %0d want 0", seen); end
    checks++; if (garm_fix[23:0] !== 24'd4) begin errors++; $display("FAIL dis_garm got %0d want 4", garm_fix[23:0]); end
    checks++; if (meas_fix[5:0] !== 6'd1) begin errors++; $display("FAIL dis_meas got %0d want 1", meas_fix[5:0]); end
  endtask

  // Ch1 falling and ch2 rising on the same sample: lags differ by 10.
  task automatic test_edge_select();
    cfg_en = 4'b0110;
    pulse();
    step_n(3);
    adc_data[3] = 1'b1;
    step_n(2 + X);
    checks++; if (sync_out !== 4'b0100) begin errors++; $display("FAIL sel_rise got %b want 0100", sync_out); end
    step_n(8 - X);
    adc_data[3] = 1'b0;
    step_n(2 + X);
    checks++; if (sync_out !== 4'b0010) begin errors++; $display("FAIL sel_fall got %b want 0010", sync_out); end
    checks++; if (lag_fix[47:32] !== 16'(4 + X)) begin errors++; $display("FAIL sel_lag2 got %0d want %0d", lag_fix[47:32], 4 + X); end
    checks++; if (lag_fix[31:16] !== 16'(14 + X)) begin errors++; $display("FAIL sel_lag1 got %0d want %0d", lag_fix[31:16], 14 + X); end
    cfg_en = 4'b0000;
    step();
  endtask

  // Ch3 with constant sign and limit 20: forced sync, then real sync clears.
  task automatic test_timeout();
    cfg_en = 4'b1000;
    cfg_timeout = 16'd20;
    pulse();
    step_n(19);
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL to_early got %b want 0000", sync_out); end
    step();
    checks++; if (sync_out !== 4'b1000) begin errors++; $display("FAIL to_sync got %b want 1000", sync_out); end
    checks++; if (fix_stb !== 4'b1000) begin errors++; $display("FAIL to_stb got %b want 1000", fix_stb); end
    checks++; if (lag_fix[63:48] !== 16'hFFFF) begin errors++; $display("FAIL to_lag got %h want ffff", lag_fix[63:48]); end
    checks++; if (timeout !== 4'b1000) begin errors++; $display("FAIL to_flag got %b want 1000", timeout); end
    step();
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL to_oneclk got %b want 0000", sync_out); end
    pulse();
    checks++; if (timeout[3] !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout[3]); end
    step_n(3);
    adc_data[5] = 1'b1;
    step_n(2 + X);
    checks++; if (sync_out !== 4'b1000) begin errors++; $display("FAIL to_real got %b want 1000", sync_out); end
    checks++; if (lag_fix[63:48] !== 16'(4 + X)) begin errors++; $display("FAIL to_reallag got %0d want %0d", lag_fix[63:48], 4 + X); end
    checks++; if (timeout[3] !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", timeout[3]); end
  endtask

  // Ch3, no limit, no edges across two pulses: missed second.
  task automatic test_missed();
    int seen;
    seen = 0;
    cfg_timeout = 16'd0;
    pulse();
    for (int i = 0; i < 30; i++) begin step(); if (sync_out[3]) seen++; end
    pulse();
    checks++; if (seen !== 0) begin errors++; $display("FAIL miss_nosync got %0d want 0", seen); end
    checks++; if (timeout[3] !== 1'b1) begin errors++; $display("FAIL miss_flag got %b want 1", timeout[3]); end
    checks++; if (meas_fix[23:18] !== 6'd3) begin errors++; $display("FAIL miss_meas got %0d want 3", meas_fix[23:18]); end
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL miss_sync got %b want 0000", sync_out); end
    cfg_en = 4'b0000;
    step();
  endtask

`ifdef REF_SYNC_DEGLITCH_EN
  // Ch0: a 2-clock glitch is rejected; a clean edge syncs at t+6.
  task automatic test_glitch();
    cfg_en = 4'b0001;
    adc_data[1] = 1'b0; step_n(2);
    adc_data[1] = 1'b1; step_n(8);
    pulse();
    checks++; if (garm_fix[23:0] !== 24'd0) begin errors++; $display("FAIL dgl_garm got %0d want 0", garm_fix[23:0]); end
    adc_data[1] = 1'b0; step_n(10);
    adc_data[1] = 1'b1;
    step_n(5);
    checks++; if (sync_out !== 4'b0000) begin errors++; $display("FAIL dgl_early got %b want 0000", sync_out); end
    step();
    checks++; if (sync_out !== 4'b0001) begin errors++; $display("FAIL dgl_sync got %b want 0001", sync_out); end
    cfg_en = 4'b0000;
  endtask
`endif

  initial begin
    rst         = 1'b1;
    adc_data    = 32'h0;
    sec_pulse   = 1'b0;
    cfg_en      = 4'b0000;
    cfg_edge    = 4'b1101;
    cfg_sel     = {4'd2, 4'd1, 4'd1, 4'd0};
    cfg_timeout = 16'd0;
    test_reset();
    test_lag();
    test_coincident();
    test_disable();
    test_edge_select();
    test_timeout();
    test_missed();
`ifdef REF_SYNC_DEGLITCH_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
